puf_eval_ctrl: RTL and testbench

//   Sequencer for the 8-bit ring-oscillator PUF array. Accepts one challenge per

---
 rtl/puf_eval_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_puf_eval_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/puf_eval_ctrl.sv
// puf_eval_ctrl: challenge/response sequencer and sole driver of the 8-bit ring-oscillator PUF array.
// Define PUF_MAJORITY_VOTE_EN to repeat the evaluation NUM_VOTES times and report a per-bit majority.
module puf_eval_ctrl #(
    parameter int RST_CYCLES  = 4,
    parameter int MEAS_CYCLES = 1024,
    parameter int NUM_VOTES   = 3
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       chal_valid_i,
    output logic       chal_ready_o,
    input  logic [7:0] chal_in_i,
    output logic       rsp_valid_o,
    input  logic       rsp_ready_i,
    output logic [7:0] rsp_out_o,
    output logic       rsp_unstable_o,
    output logic       busy_o,
    output logic [7:0] puf_challenge_o,
    output logic       puf_reset_o,
    input  logic [7:0] puf_response_i
);
    localparam int MAX_CYCLES = (RST_CYCLES > MEAS_CYCLES) ? RST_CYCLES : MEAS_CYCLES;
    localparam int CW = $clog2(MAX_CYCLES + 1);
    localparam logic [CW-1:0] RST_LAST  = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] MEAS_LAST = CW'(MEAS_CYCLES - 1);

    if (RST_CYCLES < 1 || MEAS_CYCLES < 1 || NUM_VOTES < 1 || (NUM_VOTES % 2) == 0) begin : g_bad_params
        $error("puf_eval_ctrl: illegal parameter set");
    end

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RST  = 3'd1,
        S_MEAS = 3'd2,
        S_SAMP = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    chal_q, chal_d;
    logic [7:0]    rsp_q, rsp_d;
    logic          rsp_valid_q, chal_ready_q, busy_q, puf_reset_q;

`ifdef PUF_MAJORITY_VOTE_EN
    localparam int VW = $clog2(NUM_VOTES + 1);
    localparam logic [VW-1:0] VOTE_LAST = VW'(NUM_VOTES - 1);
    localparam logic [VW-1:0] VOTE_HALF = VW'(NUM_VOTES / 2);
    localparam logic [VW-1:0] VOTE_ALL  = VW'(NUM_VOTES);

    logic [VW-1:0] vote_q, vote_d;
    logic [VW-1:0] ones_q [8];
    logic [VW-1:0] ones_d [8];
    logic          unstable_q, unstable_d;
`endif

    // Next-state, counter, challenge latch and response/vote computation
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        chal_d  = chal_q;
        rsp_d   = rsp_q;
`ifdef PUF_MAJORITY_VOTE_EN
        vote_d     = vote_q;
        unstable_d = unstable_q;
        for (int i = 0; i < 8; i++) begin
            ones_d[i] = ones_q[i];
        end
`endif
        case (state_q)
            S_IDLE: begin
                if (chal_valid_i) begin
                    state_d = S_RST;
                    chal_d  = chal_in_i;
                    cnt_d   = {CW{1'b0}};
`ifdef PUF_MAJORITY_VOTE_EN
                    vote_d = {VW{1'b0}};
                    for (int i = 0; i < 8; i++) begin
                        ones_d[i] = {VW{1'b0}};
                    end
`endif
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RST: begin
                if (cnt_q == RST_LAST) begin
                    cnt_d   = {CW{1'b0}};
                    state_d = S_MEAS;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_MEAS: begin
                if (cnt_q == MEAS_LAST) begin
                    cnt_d   = {CW{1'b0}};
                    state_d = S_SAMP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_SAMP: begin
`ifdef PUF_MAJORITY_VOTE_EN
                for (int i = 0; i < 8; i++) begin
                    ones_d[i] = ones_q[i] + VW'(puf_response_i[i]);
                end
                if (vote_q == VOTE_LAST) begin
                    state_d    = S_DONE;
                    unstable_d = 1'b0;
                    for (int i = 0; i < 8; i++) begin
                        rsp_d[i] = (ones_d[i] > VOTE_HALF);
                        if (ones_d[i] != {VW{1'b0}} && ones_d[i] != VOTE_ALL) begin
                            unstable_d = 1'b1;
                        end else begin
                            unstable_d = unstable_d;
                        end
                    end
                end else begin
                    vote_d  = vote_q + VW'(1);
                    state_d = S_RST;
                end
`else
                rsp_d   = puf_response_i;
                state_d = S_DONE;
`endif
            end
            S_DONE: begin
                if (rsp_ready_i) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = {CW{1'b0}};
            end
        endcase
    end

    // State, counters and registered outputs; outputs reflect the state being entered
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= S_IDLE;
            cnt_q        <= {CW{1'b0}};
            chal_q       <= 8'h00;
            rsp_q        <= 8'h00;
            rsp_valid_q  <= 1'b0;
            chal_ready_q <= 1'b0;
            busy_q       <= 1'b0;
            puf_reset_q  <= 1'b1;
`ifdef PUF_MAJORITY_VOTE_EN
            vote_q     <= {VW{1'b0}};
            unstable_q <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                ones_q[i] <= {VW{1'b0}};
            end
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            chal_q       <= chal_d;
            rsp_q        <= rsp_d;
            rsp_valid_q  <= (state_d == S_DONE);
            chal_ready_q <= (state_d == S_IDLE);
            busy_q       <= (state_d != S_IDLE);
            puf_reset_q  <= (state_d == S_RST);
`ifdef PUF_MAJORITY_VOTE_EN
            vote_q     <= vote_d;
            unstable_q <= unstable_d;
            for (int i = 0; i < 8; i++) begin
                ones_q[i] <= ones_d[i];
            end
`endif
        end
    end

    assign chal_ready_o    = chal_ready_q;
    assign rsp_valid_o     = rsp_valid_q;
    assign rsp_out_o       = rsp_q;
    assign busy_o          = busy_q;
    assign puf_challenge_o = chal_q;
    assign puf_reset_o     = puf_reset_q;
`ifdef PUF_MAJORITY_VOTE_EN
    assign rsp_unstable_o  = unstable_q;
`else
    assign rsp_unstable_o  = 1'b0;
`endif

endmodule

// File: tb/tb_puf_eval_ctrl.sv
// Self-checking bench for puf_eval_ctrl with a behavioural PUF array and response model.
// Voting scenarios are included when PUF_MAJORITY_VOTE_EN is defined.
module tb_puf_eval_ctrl;
    localparam int R  = 2;
    localparam int M  = 5;
    localparam int NV = 3;
`ifdef PUF_MAJORITY_VOTE_EN
    localparam int V = NV;
`else
    localparam int V = 1;
`endif
    localparam int PERIOD = R + M + 1;
    localparam int LAT    = V * PERIOD + 1;

    logic       clk = 1'b0;
    logic       reset;
    logic       chal_valid;
    logic       chal_ready;
    logic [7:0] chal_in;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_out;
    logic       rsp_unstable;
    logic       busy;
    logic [7:0] puf_challenge;
    logic       puf_reset;
    logic [7:0] puf_response;

    int         tests = 0;
    int         fails = 0;
    logic [7:0] tbl [NV];
    int         eval_n = 0;
    logic       prev_rst = 1'b1;
    logic [7:0] c;

    always #5 clk = ~clk;

    puf_eval_ctrl #(.RST_CYCLES(R), .MEAS_CYCLES(M), .NUM_VOTES(NV)) dut (
        .clk_i           (clk),
        .reset_i         (reset),
        .chal_valid_i    (chal_valid),
        .chal_ready_o    (chal_ready),
        .chal_in_i       (chal_in),
        .rsp_valid_o     (rsp_valid),
        .rsp_ready_i     (rsp_ready),
        .rsp_out_o       (rsp_out),
        .rsp_unstable_o  (rsp_unstable),
        .busy_o          (busy),
        .puf_challenge_o (puf_challenge),
        .puf_reset_o     (puf_reset),
        .puf_response_i  (puf_response)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Array model: each new reset pulse during an evaluation starts the next entry of tbl
    task automatic tick();
        int idx;
        @(posedge clk);
        #1;
        if (busy === 1'b1 && puf_reset === 1'b1 && prev_rst === 1'b0) eval_n++;
        prev_rst = puf_reset;
        idx = (eval_n == 0) ? 0 : eval_n - 1;
        if (idx >= NV) idx = NV - 1;
        puf_response = tbl[idx];
    endtask

    // Expected {unstable, response}: per-bit majority of the V evaluations
    function automatic logic [8:0] model_rsp();
        logic [7:0] r;
        logic       u;
        int         ones;
        r = 8'h00;
        u = 1'b0;
        for (int b = 0; b < 8; b++) begin
            ones = 0;
            for (int v = 0; v < V; v++) ones += int'(tbl[v][b]);
            r[b] = (2 * ones > V);
            if (ones != 0 && ones != V) u = 1'b1;
        end
        return {u, r};
    endfunction

    task automatic rand_tbl();
        for (int v = 0; v < NV; v++) tbl[v] = 8'($urandom);
    endtask

    // Runs one challenge from IDLE up to the first rsp_valid cycle, checking the array timing
    task automatic do_eval(input logic [7:0] chal, input bit keep_valid, input bit inject);
        logic [8:0] exp;
        exp = model_rsp();
        chal_in    = chal;
        chal_valid = 1'b1;
        chk("accept_ready", 32'(chal_ready), 32'd1);
        eval_n = 0;
        for (int k = 1; k <= LAT; k++) begin
            tick();
            if (k == 1 && !keep_valid) chal_valid = 1'b0;
            if (k < LAT) begin
                chk("rsp_valid_early", 32'(rsp_valid), 32'd0);
                chk("busy_eval", 32'(busy), 32'd1);
                chk("puf_reset_pattern", 32'(puf_reset), 32'(((k - 1) % PERIOD) < R));
                chk("chal_stable", 32'(puf_challenge), 32'(chal));
            end else begin
                chk("rsp_valid_latency", 32'(rsp_valid), 32'd1);
                chk("rsp_out", 32'(rsp_out), 32'(exp[7:0]));
                chk("rsp_unstable", 32'(rsp_unstable), 32'(exp[8]));
                chk("puf_reset_done", 32'(puf_reset), 32'd0);
                chk("eval_count", 32'(eval_n), 32'(V));
            end
            if (inject && k == R + 2) begin
                chal_valid = 1'b1;
                chal_in    = 8'hFF;
            end
            if (inject && k == R + 4) chal_valid = 1'b0;
        end
    endtask

    task automatic handshake();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("rsp_valid_drop", 32'(rsp_valid), 32'd0);
        chk("idle_ready", 32'(chal_ready), 32'd1);
        chk("idle_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        reset        = 1'b1;
        chal_valid   = 1'b0;
        chal_in      = 8'h00;
        rsp_ready    = 1'b0;
        puf_response = 8'h00;
        for (int v = 0; v < NV; v++) tbl[v] = 8'h00;
        repeat (3) tick();
        chk("rst_chal_ready", 32'(chal_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_out", 32'(rsp_out), 32'd0);
        chk("rst_unstable", 32'(rsp_unstable), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_puf_chal", 32'(puf_challenge), 32'd0);
        chk("rst_puf_reset", 32'(puf_reset), 32'd1);
        reset = 1'b0;
        tick();
        chk("post_rst_ready", 32'(chal_ready), 32'd1);
        chk("post_rst_puf_reset", 32'(puf_reset), 32'd0);

        // Directed: 0xA5 -> 0x3C, busy-time 0xFF request ignored, long stall on rsp_ready
        for (int v = 0; v < NV; v++) tbl[v] = 8'h3C;
        do_eval(8'hA5, 1'b0, 1'b1);
        chk("dir_rsp", 32'(rsp_out), 32'h3C);
        chk("dir_chal", 32'(puf_challenge), 32'hA5);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("hold_valid", 32'(rsp_valid), 32'd1);
            chk("hold_rsp", 32'(rsp_out), 32'h3C);
        end
        handshake();
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("no_extra_busy", 32'(busy), 32'd0);
            chk("no_extra_rsp", 32'(rsp_valid), 32'd0);
            chk("no_extra_chal", 32'(puf_challenge), 32'hA5);
        end

        // Reset in the middle of the measurement window
        rand_tbl();
        chal_in    = 8'($urandom);
        chal_valid = 1'b1;
        tick();
        chal_valid = 1'b0;
        repeat (R + 1) tick();
        chk("abort_in_meas", 32'(puf_reset), 32'd0);
        reset = 1'b1;
        tick();
        chk("abort_puf_reset", 32'(puf_reset), 32'd1);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("abort_chal", 32'(puf_challenge), 32'd0);
        reset = 1'b0;
        tick();
        chk("abort_ready", 32'(chal_ready), 32'd1);
        rand_tbl();
        do_eval(8'($urandom), 1'b0, 1'b0);
        handshake();

`ifdef PUF_MAJORITY_VOTE_EN
        tbl[0] = 8'h0F;
        tbl[1] = 8'h0F;
        tbl[2] = 8'h1F;
        do_eval(8'h5A, 1'b0, 1'b0);
        chk("vote_rsp", 32'(rsp_out), 32'h0F);
        chk("vote_unstable", 32'(rsp_unstable), 32'd1);
        handshake();
        for (int v = 0; v < NV; v++) tbl[v] = 8'h81;
        do_eval(8'hC3, 1'b0, 1'b0);
        chk("vote_const_rsp", 32'(rsp_out), 32'h81);
        chk("vote_const_stable", 32'(rsp_unstable), 32'd0);
        handshake();
`endif

        // Random challenges and responses with random consumer stalls
        for (int n = 0; n < 8; n++) begin
            rand_tbl();
            do_eval(8'($urandom), 1'b0, 1'b0);
            for (int w = 0; w < int'($urandom_range(4, 0)); w++) begin
                tick();
                chk("rand_hold", 32'(rsp_valid), 32'd1);
            end
            handshake();
        end

        // Back-to-back with rsp_ready and chal_valid held high
        rsp_ready = 1'b1;
        for (int b = 0; b < 3; b++) begin
            rand_tbl();
            c = 8'($urandom);
            do_eval(c, 1'b1, 1'b0);
            chal_in = c ^ 8'hFF;
            tick();
            chk("b2b_gap_busy", 32'(busy), 32'd0);
            chk("b2b_gap_ready", 32'(chal_ready), 32'd1);
            chk("b2b_gap_valid", 32'(rsp_valid), 32'd0);
            chk("b2b_not_latched", 32'(puf_challenge), 32'(c));
        end
        chal_valid = 1'b0;
        rsp_ready  = 1'b0;
        tick();
        chk("final_idle", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
